// File: rtl/key_sampler.sv
// Button front-end for the guessing round: synchronizes and debounces two
// active-low keys and turns the first decision of an armed round into one-cycle pulses.
module key_sampler #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CHORD_CYCLES    = 50_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1_n,
  input  logic       key0_n,
  input  logic       arm,
  output logic       armed,
  output logic       key_same,
  output logic       key_diff,
  output logic       lvl_same,
  output logic       lvl_diff,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_CHORD    = 3'd2,
    S_EMIT     = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CH_LAST     = CNT_W'(CHORD_CYCLES - 1);
  localparam logic [CNT_W:0]   SETTLE_LAST = (CNT_W+1)'(DEBOUNCE_CYCLES + 2);

  // Key vectors: bit 1 = "same" (KEY1), bit 0 = "diff" (KEY0).
  logic [1:0]       r_sync_same;
  logic [1:0]       r_sync_diff;
  logic [1:0]       w_sync;
  logic [1:0]       r_lvl;
  logic [1:0]       r_lvl_q;
  logic [1:0]       w_press;
  logic [CNT_W-1:0] r_db_cnt [2];
  logic [CNT_W:0]   r_settle;
  logic             r_ready;
  state_t           r_state;
  logic [1:0]       r_first;
  logic [1:0]       r_pulse;
  logic [CNT_W-1:0] r_chord_cnt;
  logic             r_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_same <= 2'b11;
      r_sync_diff <= 2'b11;
    end else begin
      r_sync_same <= {r_sync_same[0], key1_n};
      r_sync_diff <= {r_sync_diff[0], key0_n};
    end
  end

  assign w_sync = {~r_sync_same[1], ~r_sync_diff[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
      r_lvl   <= 2'b00;
      r_lvl_q <= 2'b00;
    end else begin
      r_lvl_q <= r_lvl;
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_lvl[i]    <= w_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Keys held through reset look released until the debouncer catches up;
  // the rise that follows is not a fresh press, so events stay masked until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
      r_ready  <= 1'b0;
    end else if (!r_ready) begin
      r_settle <= r_settle + (CNT_W+1)'(1);
      if (r_settle == SETTLE_LAST) r_ready <= 1'b1;
    end
  end

  assign w_press = r_lvl & ~r_lvl_q & {2{r_ready}};

  // Handshake: arm is a request taken only in IDLE (no queueing, no ready);
  // each accepted arm yields exactly one key_same/key_diff pulse, never while armed=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_first     <= 2'b00;
      r_pulse     <= 2'b00;
      r_chord_cnt <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_pulse <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end
        end
        S_ARMED: begin
          if (w_press == 2'b11) begin
            r_state <= S_EMIT;
            r_pulse <= 2'b11;
            r_armed <= 1'b0;
          end else if (w_press != 2'b00) begin
            r_state     <= S_CHORD;
            r_first     <= w_press;
            r_chord_cnt <= '0;
          end
        end
        S_CHORD: begin
          r_chord_cnt <= r_chord_cnt + CNT_W'(1);
          if ((w_press & ~r_first) != 2'b00) begin
            r_state <= S_EMIT;
            r_pulse <= 2'b11;
            r_armed <= 1'b0;
          end else if (r_chord_cnt == CH_LAST) begin
            r_state <= S_EMIT;
            r_pulse <= r_first;
            r_armed <= 1'b0;
          end
        end
        S_EMIT: r_state <= S_WAIT_REL;
        S_WAIT_REL: begin
          if (r_lvl == 2'b00) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign armed     = r_armed;
  assign key_same  = r_pulse[1];
  assign key_diff  = r_pulse[0];
  assign lvl_same  = r_lvl[1];
  assign lvl_diff  = r_lvl[0];
  assign dbg_state = r_state;

endmodule

// File: doc/key_sampler.md
# key_sampler

Input front-end for the guessing round. It synchronizes and debounces the two raw, active-low push buttons: KEY1 means "same" and KEY0 means "diff". It accepts exactly one decision per armed round and emits one-cycle `key_same` / `key_diff` pulses to the win/lose judge. A near-simultaneous press of both buttons inside a chord window is reported as both pulses high in the same cycle, which the judge scores as an illegal press.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a synchronized key level must hold before the debounced level follows it (20 ms at 50 MHz).
- `CHORD_CYCLES`, 50_000: window after the first accepted press during which a press of the other key counts as simultaneous.
- `CNT_W`, 20: width of the debounce and chord counters. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, CHORD_CYCLES).

Clocking and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `key1_n`  in  1  raw "same" button, active-low, asynchronous to `clk`.
- `key0_n`  in  1  raw "diff" button, active-low, asynchronous to `clk`.
- `arm`  in  1  request to open a decision round; sampled only in IDLE.
- `armed`  out  1  high in ARMED and CHORD.
- `key_same`  out  1  one-cycle decision pulse, registered.
- `key_diff`  out  1  one-cycle decision pulse, registered.
- `lvl_same`  out  1  debounced "same" level, active-high (for LEDs).
- `lvl_diff`  out  1  debounced "diff" level, active-high.

## Operation
- **Synchronizer:** each raw key passes through 2 flip-flops, which reset to 1 (released), and is then inverted to active-high.
- **Debouncer (per key):**
  - The counter clears whenever the synchronized value equals `lvl_x`.
  - While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, `lvl_x` takes the synchronized value and the counter clears.
- **Press event:** `lvl_x`=1 in a cycle where `lvl_x` was 0 in the previous cycle (registered copy).
- **FSM states:**
  - IDLE: `arm`=1 goes to ARMED. Press events are ignored.
  - ARMED:
    - Both press events in the same cycle go to EMIT with both pulses set.
    - One press event goes to CHORD, records which key was first, and clears the chord timer.
    - A key already held when entering ARMED never produces an event until it is released and pressed again.
  - CHORD: the timer increments every cycle.
    - A press event of the other key goes to EMIT with both pulses set.
    - Otherwise, when the timer reaches CHORD_CYCLES-1, go to EMIT with only the first key's pulse set.
    - Releasing the first key inside the window does not cancel the decision.
  - EMIT: the selected pulse(s) are high for this single cycle. The next state is WAIT_REL.
  - WAIT_REL: when `lvl_same`=0 and `lvl_diff`=0, go to IDLE.
- `arm` outside IDLE is ignored. There is no queued arm.
- Exactly one EMIT occurs per arm accepted in IDLE.

## Timing
- **Reset values:**
  - Outputs: `armed`=0, `key_same`=0, `key_diff`=0, `lvl_same`=0, `lvl_diff`=0.
  - Internal: FSM=IDLE, counters=0, synchronizer flip-flops=1.
- **Raw edge to `lvl_x` change:** 2 synchronizer cycles plus DEBOUNCE_CYCLES cycles, with the raw level held stable throughout. Any bounce restarts the count.
- **ARMED entry:** `arm` high at IDLE edge t gives `armed`=1 from t+1.
- **Single press:** press event in ARMED at cycle t gives CHORD at t+1 and the pulse at t+1+CHORD_CYCLES, high for exactly 1 cycle.
- **Chord press:** second-key event in CHORD at cycle u gives both pulses high at u+1.
- `armed` falls in the cycle EMIT is entered. The pulses never coincide with `armed`=1.
- **Reset mid-round:** returns to IDLE immediately. No pulse is issued, and a held key after reset needs a fresh release and press in a new round.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, CHORD_CYCLES=3.

1. **Reset and idle:** hold `rst` 3 cycles, then drive `key1_n`=0 without `arm` for 20 cycles.
   - `lvl_same`=1 after 6 cycles.
   - `key_same` and `key_diff` stay 0 and `armed` stays 0.
2. **Single "same":** pulse `arm`, then drive `key1_n`=0 and hold.
   - Exactly one `key_same`=1 cycle, 4 cycles after `lvl_same` rises; `key_diff`=0 throughout.
   - FSM stays in WAIT_REL until release, then `armed`=0 and IDLE.
3. **Bounce rejection:** armed; toggle `key0_n` 0/1 every 2 cycles for 20 cycles, then hold at 1.
   - `lvl_diff` never rises and no pulse is issued.
4. **Chord:** armed; `key0_n`=0, then `key1_n`=0 two cycles later.
   - `key_same`=1 and `key_diff`=1 together for 1 cycle; no separate single pulse.
5. **Late second key:** armed; `key1_n`=0, then `key0_n`=0 six cycles later.
   - Only `key_same` pulses.
   - A second `arm` while the keys are held yields no pulse until both are released and one is re-pressed.
6. **Reset mid-CHORD:** armed; press `key1_n`, assert `rst` during CHORD.
   - No pulse; all outputs return to 0.
   - After reset, `arm` with `key1_n` still held gives no pulse.
